// File: rtl/busy_table.sv
// Busy-bit store for the physical register file.
// The map stage sets or clears one bit per cycle. Writeback ports clear bits.
// Read ports report operand readiness combinationally, and a same-cycle
// writeback clear is forwarded into the read result.
// A registered popcount of the busy bits tracks the bit vector exactly.
module busy_table #(
  parameter  int PHY_RF_DEPTH = 128,
  parameter  int NUM_WB       = 2,
  parameter  int NUM_RD       = 4,
  localparam int PRA_W        = $clog2(PHY_RF_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    busy_table_wr_en,
  input  logic [PRA_W-1:0]        busy_table_wr_addr,
  input  logic                    busy_table_data_in,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*PRA_W-1:0] wb_addr,
  input  logic                    flush,
  input  logic [NUM_RD*PRA_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic [PRA_W:0]          busy_count
);

  // Addresses at or above this limit do not exist. They are only reachable
  // when the depth is not a power of two.
  localparam logic [PRA_W:0] DEPTH_LIM = (PRA_W+1)'(PHY_RF_DEPTH);

  logic [PHY_RF_DEPTH-1:0] bits_q, bits_d;
  logic [PRA_W:0]          count_q, count_d;

  function automatic logic in_range(input logic [PRA_W-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  // True when any valid writeback port targets address a in this cycle.
  function automatic logic wb_hit(input logic [PRA_W-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && (wb_addr[k*PRA_W +: PRA_W] == a)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Next-state bits. Clears are applied first and the map write last, so a
  // map write of 1 wins over a clear and a map write of 0 also ends at 0.
  // A flush wipes everything, and entry 0 is always forced to ready.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    bits_d = bits_q;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && in_range(wb_addr[k*PRA_W +: PRA_W])) begin
        bits_d[wb_addr[k*PRA_W +: PRA_W]] = 1'b0;
      end
    end
    if (busy_table_wr_en && in_range(busy_table_wr_addr)) begin
      bits_d[busy_table_wr_addr] = busy_table_data_in;
    end
    bits_d[0] = 1'b0;
    if (flush) bits_d = '0;
  end

  // Population count of the post-update vector. It is registered together
  // with the bits, so busy_count always matches what the read ports see.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < PHY_RF_DEPTH; i++) begin
      count_d = count_d + (PRA_W+1)'(bits_d[i]);
    end
  end

  // State registers with a synchronous reset. Reset takes priority over
  // every write in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: the busy bits are plain flops rather than a RAM, so they are all
    // reset; issue logic must never see a stale busy bit after reset.
    if (rst) begin
      bits_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: use non-blocking assignments for sequential state so that every
      // flop samples values from before the edge.
      bits_q  <= bits_d;
      count_q <= count_d;
    end
  end

  // Read ports. A same-cycle writeback clear is forwarded into the result.
  // A same-cycle map set is not forwarded.
  always_comb begin
    rd_busy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rd_busy[j] = in_range(rd_addr[j*PRA_W +: PRA_W])
                 && bits_q[rd_addr[j*PRA_W +: PRA_W]]
                 && !wb_hit(rd_addr[j*PRA_W +: PRA_W]);
    end
  end

  assign busy_count = count_q;

endmodule

// File: tb/tb_busy_table.sv
// Self-checking bench for busy_table: directed vector table, hand-written
// multi-cycle sequences, and random traffic checked against a behavioural
// model.
module tb_busy_table;

  localparam int DEPTH = 128;
  localparam int PW    = 7;
  localparam int NRD   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            busy_table_wr_en;
  logic [PW-1:0]   busy_table_wr_addr;
  logic            busy_table_data_in;
  logic [1:0]      wb_valid;
  logic [2*PW-1:0] wb_addr;
  logic            flush;
  logic [4*PW-1:0] rd_addr;
  logic [3:0]      rd_busy;
  logic [PW:0]     busy_count;

  busy_table dut (
    .clk               (clk),
    .rst               (rst),
    .busy_table_wr_en  (busy_table_wr_en),
    .busy_table_wr_addr(busy_table_wr_addr),
    .busy_table_data_in(busy_table_data_in),
    .wb_valid          (wb_valid),
    .wb_addr           (wb_addr),
    .flush             (flush),
    .rd_addr           (rd_addr),
    .rd_busy           (rd_busy),
    .busy_count        (busy_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one bit per register, updated according to the
  // priority rules for flush, reset, writeback clears and map writes.
  bit model_bits[DEPTH];

  typedef struct {
    bit       we;
    int       wa;
    bit       wd;
    bit [1:0] wv;
    int       a0;
    int       a1;
    int       r[NRD];
    bit [3:0] eb;
    int       ec;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(bit we, int wa, bit wd, bit [1:0] wv, int a0, int a1,
                              int r0, int r1, int r2, int r3, bit [3:0] eb, int ec);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.wv = wv; v.a0 = a0; v.a1 = a1;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
    v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit we, input int wa, input bit wd, input bit [1:0] wv,
                       input int a0, input int a1, input bit fl,
                       input int r0, input int r1, input int r2, input int r3);
    busy_table_wr_en   = we;
    busy_table_wr_addr = PW'(wa);
    busy_table_data_in = wd;
    wb_valid           = wv;
    wb_addr            = {PW'(a1), PW'(a0)};
    flush              = fl;
    rd_addr            = {PW'(r3), PW'(r2), PW'(r1), PW'(r0)};
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(model_bits[i]);
    return c;
  endfunction

  // Expected read result: the stored bit, unless a valid writeback port
  // targets the same address in this cycle.
  function automatic bit model_rd(int a);
    bit cleared = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (wb_valid[k] && int'(wb_addr[k*PW +: PW]) == a) cleared = 1'b1;
    end
    return model_bits[a] && !cleared;
  endfunction

  // Compute the model's next state from the current inputs, then step one edge.
  task automatic advance();
    bit nxt[DEPTH];
    nxt = model_bits;
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) nxt[i] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wb_valid[k]) nxt[int'(wb_addr[k*PW +: PW])] = 1'b0;
      end
      if (busy_table_wr_en && busy_table_wr_addr != 0) begin
        nxt[int'(busy_table_wr_addr)] = busy_table_data_in;
      end
    end
    @(posedge clk);
    model_bits = nxt;
    #1;
  endtask

  task automatic check_model(input string tag);
    for (int j = 0; j < NRD; j++) begin
      check($sformatf("%s rd%0d", tag, j), int'(rd_busy[j]),
            int'(model_rd(int'(rd_addr[j*PW +: PW]))));
    end
    check($sformatf("%s count", tag), int'(busy_count), model_count());
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 5, 1, 2'b00, 0, 0, 0, 5, 5, 5, 5);

    // Reset held with a concurrent write to address 5: the write must be lost.
    advance();
    advance();
    rst = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 5, 5, 0, 1);
    @(negedge clk);
    check("reset rd_busy", int'(rd_busy), 0);
    check("reset count", int'(busy_count), 0);
    advance();

    // Directed vectors. Each row is applied, then checked at the negedge
    // before the edge that commits it.
    tbl[0]  = mk(1, 7, 1, 2'b00, 0, 0,  7, 0, 5, 9, 4'b0000, 0);
    tbl[1]  = mk(0, 0, 0, 2'b00, 0, 0,  7, 0, 5, 9, 4'b0001, 1);
    tbl[2]  = mk(0, 0, 0, 2'b01, 7, 0,  7, 0, 5, 9, 4'b0000, 1);
    tbl[3]  = mk(0, 0, 0, 2'b00, 0, 0,  7, 0, 5, 9, 4'b0000, 0);
    tbl[4]  = mk(1, 9, 1, 2'b10, 0, 9,  9, 7, 0, 5, 4'b0000, 0);
    tbl[5]  = mk(0, 0, 0, 2'b00, 0, 0,  9, 7, 0, 5, 4'b0001, 1);
    tbl[6]  = mk(0, 0, 0, 2'b11, 9, 9,  9, 9, 9, 9, 4'b0000, 1);
    tbl[7]  = mk(0, 0, 0, 2'b00, 0, 0,  9, 9, 9, 9, 4'b0000, 0);
    tbl[8]  = mk(1, 0, 1, 2'b00, 0, 0,  0, 0, 0, 0, 4'b0000, 0);
    tbl[9]  = mk(0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 4'b0000, 0);
    tbl[10] = mk(1, 5, 1, 2'b00, 0, 0,  5, 5, 5, 5, 4'b0000, 0);
    tbl[11] = mk(1, 5, 0, 2'b01, 5, 0,  5, 5, 6, 7, 4'b0000, 1);
    tbl[12] = mk(0, 0, 0, 2'b00, 0, 0,  5, 5, 5, 5, 4'b0000, 0);
    tbl[13] = mk(1, 6, 1, 2'b00, 0, 0,  6, 6, 6, 6, 4'b0000, 0);
    tbl[14] = mk(1, 6, 1, 2'b00, 0, 0,  6, 5, 6, 0, 4'b0101, 1);
    tbl[15] = mk(0, 0, 0, 2'b01, 20, 0, 6, 20, 0, 0, 4'b0001, 1);
    tbl[16] = mk(1, 8, 0, 2'b00, 0, 0,  6, 8, 0, 0, 4'b0001, 1);
    tbl[17] = mk(0, 0, 0, 2'b00, 0, 0,  6, 8, 0, 0, 4'b0001, 1);
    tbl[18] = mk(0, 0, 0, 2'b10, 6, 6,  6, 6, 8, 8, 4'b0000, 1);
    tbl[19] = mk(0, 0, 0, 2'b00, 0, 0,  6, 6, 8, 8, 4'b0000, 0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wv, tbl[i].a0, tbl[i].a1, 0,
            tbl[i].r[0], tbl[i].r[1], tbl[i].r[2], tbl[i].r[3]);
      @(negedge clk);
      check($sformatf("tbl%0d rd_busy", i), int'(rd_busy), int'(tbl[i].eb));
      check($sformatf("tbl%0d count", i), int'(busy_count), tbl[i].ec);
      advance();
    end

    // Fill every real entry, then re-set an entry that is already busy at the maximum count.
    for (int a = 1; a < DEPTH; a++) begin
      drive(1, a, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      advance();
    end
    drive(1, 127, 1, 2'b00, 0, 0, 0, 1, 64, 127, 3);
    @(negedge clk);
    check("fill count", int'(busy_count), 127);
    check("fill rd_busy", int'(rd_busy), 15);
    advance();
    drive(1, 3, 1, 2'b00, 0, 0, 1, 3, 0, 127, 1);
    @(negedge clk);
    check("max idempotent count", int'(busy_count), 127);
    advance();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 3, 0, 127, 1);
    @(negedge clk);
    check("flush count", int'(busy_count), 0);
    check("flush rd_busy", int'(rd_busy), 0);
    advance();

    // Reset arriving on an already-busy table, with a concurrent write.
    drive(1, 5, 1, 2'b00, 0, 0, 0, 5, 5, 5, 5);
    advance();
    rst = 1'b1;
    drive(1, 5, 1, 2'b00, 0, 0, 0, 5, 5, 5, 5);
    @(negedge clk);
    check("pre-reset count", int'(busy_count), 1);
    advance();
    rst = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 5, 5, 5, 5);
    @(negedge clk);
    check("reset2 rd_busy", int'(rd_busy), 0);
    check("reset2 count", int'(busy_count), 0);
    advance();

    // Random traffic. Half of the addresses come from a narrow window so
    // that ports often collide on the same address.
    for (int c = 0; c < 3000; c++) begin
      int lim;
      lim = ($urandom_range(0, 1) == 0) ? 15 : DEPTH - 1;
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, lim), $urandom_range(0, 9) < 7,
            2'($urandom_range(0, 3)), $urandom_range(0, lim), $urandom_range(0, lim),
            $urandom_range(0, 99) == 0,
            $urandom_range(0, lim), $urandom_range(0, lim),
            $urandom_range(0, lim), $urandom_range(0, lim));
      @(negedge clk);
      check_model($sformatf("rnd%0d", c));
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
